game_state_sequencer: RTL and testbench
=======================================

# game_state_sequencer

Top-level game-flow FSM that sequences the physics engine: it issues one physics step per rendered frame, loads levels, holds the ball for serve, and counts lives. It also runs inter-round delays and the game-over/restart cycle. It sits between the video frame strobe, the player buttons and the physics/score datapath, and takes over lives and game-over bookkeeping from the game controller.

## Interface
Parameters:
- START_LIVES, 5: lives loaded at reset and restart (3 bits, 1..7)
- LOST_DELAY_FRAMES, 60: frames spent in LOST before re-serve (1..255)
- CLEAR_DELAY_FRAMES, 90: frames spent in CLEAR before next level load (1..255)
- LEVEL_COUNT, 4: number of levels; LEVEL wraps to 0 after LEVEL_COUNT-1

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  reset, synchronous, active-low
- FRAME_RENDERED  in  1  one-cycle pulse per video frame
- BTN_RELEASE  in  1  debounced serve/restart button (level)
- SW_PAUSE  in  1  pause switch (level)
- SW_IGNORE_DEATH  in  1  ball loss costs no life; the sequencer stays in PLAY
- STEP_COMPLETE  in  1  physics step finished (pulse)
- BALL_LOST  in  1  valid with STEP_COMPLETE
- BLOCKS_LEFT  in  7  live blocks, valid with STEP_COMPLETE
- LOAD_DONE  in  1  physics finished restoring all blocks
- START_UPDATE  out  1  one-cycle step request to physics
- LOAD_LEVEL  out  1  level-load request, held until LOAD_DONE
- BALL_HELD  out  1  ball glued to paddle (SERVE/LOAD)
- SCORE_CLEAR  out  1  one-cycle pulse resetting score counters
- LIVES  out  3  remaining lives
- LEVEL  out  3  current level index
- GAME_OVER  out  1  high in OVER state
- PHASE  out  3  current state encoding
- FRAME_DROPS  out  8  saturating count of frames skipped while a step was outstanding

## Operation
- States: LOAD=0, SERVE=1, PLAY=2, LOST=3, CLEAR=4, OVER=5; other codes recover to LOAD.
- Reset: PHASE=LOAD, LIVES=START_LIVES, LEVEL=0, GAME_OVER=0, BALL_HELD=1, START_UPDATE=0, SCORE_CLEAR=0, FRAME_DROPS=0, busy=0, delay counter=0, button edge register=1 (so a button held through reset does not serve).
- Release edge: BTN_RELEASE high this cycle and low in the previous cycle.
- Step issue (SERVE and PLAY only):
  - FRAME_RENDERED && !SW_PAUSE && !busy → START_UPDATE=1 next cycle, busy set.
  - STEP_COMPLETE while busy clears busy; STEP_COMPLETE while !busy is ignored.
  - FRAME_RENDERED && !SW_PAUSE && busy → FRAME_DROPS+1, saturating at 255.
- LOAD: LOAD_LEVEL=1 while in state. LOAD_DONE → SERVE.
- SERVE: BALL_HELD=1. Steps run so the paddle moves. A release edge with !SW_PAUSE → PLAY.
- PLAY: BALL_HELD=0. The STEP_COMPLETE that clears busy is evaluated in priority order:
  1. BLOCKS_LEFT==0 → CLEAR. No life is lost even if BALL_LOST is also set.
  2. Else BALL_LOST && !SW_IGNORE_DEATH → LIVES-1. If the new LIVES is 0 → OVER, else → LOST.
  3. Else stay in PLAY.
- LOST / CLEAR:
  - Delay counter is cleared on entry and increments on FRAME_RENDERED && !SW_PAUSE.
  - When the count reaches LOST_DELAY_FRAMES → SERVE.
  - When the count reaches CLEAR_DELAY_FRAMES → LEVEL advances (wrapping) and the state goes to LOAD.
  - No steps are issued in either state.
- OVER: GAME_OVER=1, LIVES=0. A release edge → LIVES=START_LIVES, LEVEL=0, SCORE_CLEAR pulse, → LOAD.
- SW_PAUSE freezes step issue, delay counting and serve. It does not block LOAD or the OVER restart.

## Timing
- All outputs are registered. START_UPDATE rises 1 cycle after the qualifying FRAME_RENDERED.
- State transitions take effect on the edge after their trigger is sampled. LIVES and LEVEL update on the same edge as the transition.
- SCORE_CLEAR asserts in the first cycle of LOAD after a restart.
- LOAD_LEVEL asserts in the first cycle of LOAD and deasserts the cycle after LOAD_DONE is sampled. LOAD_DONE outside LOAD is ignored.
- STEP_COMPLETE may arrive 1 cycle after START_UPDATE at the earliest. It may arrive in the same cycle as FRAME_RENDERED; completion is processed first, so the new frame issues a step.
- RESET_N low mid-operation: reset values on the next edge. An outstanding step is forgotten, and a late STEP_COMPLETE is ignored.

## Structure
- Shared include game-states.v holds the PHASE encodings and the FRAME_DROPS width. Both physics and display use PHASE.
- One sub-module, frame_delay_timer: 8-bit counter with clear, enable (frame && !pause), compile-time limit input and a DONE flag. Instantiated once and shared by LOST and CLEAR with the limit muxed by state.
- Reuse GenericCounter for FRAME_DROPS is not allowed, because it wraps and this counter must saturate.

## Test plan
- Reset, LOAD_DONE after 3 cycles → LOAD_LEVEL high for exactly cycles 1-4, PHASE=SERVE, BALL_HELD=1, LIVES=5.
- In SERVE, 3 frames then a release edge → 3 START_UPDATE pulses, PHASE=PLAY. With SW_PAUSE=1, frames and the release edge produce no pulse or transition.
- PLAY with LOST_DELAY_FRAMES=3: STEP_COMPLETE with BALL_LOST=1 → LIVES=4, PHASE=LOST, SERVE after the 3rd frame. Repeat 4 more times → PHASE=OVER, GAME_OVER=1, LIVES=0.
- STEP_COMPLETE with BALL_LOST=1 and BLOCKS_LEFT=0 at LEVEL=3, LEVEL_COUNT=4 → LIVES unchanged, CLEAR, then LEVEL=0 and PHASE=LOAD.
- Two frames while the step is outstanding, then a frame in the same cycle as STEP_COMPLETE → FRAME_DROPS=2, and the next step is issued 1 cycle later. 300 drops → FRAME_DROPS=255.
- In OVER, a release edge → SCORE_CLEAR one cycle, LIVES=5, LEVEL=0. RESET_N low during PLAY with busy set, then a late STEP_COMPLETE → no state change from the reset values.

Source files
------------

// File: rtl/game_state_sequencer_pkg.sv
// Shared definitions for the game-flow sequencer: PHASE encodings seen by
// physics and display, drop-counter width, and the level wrap helper.
package game_state_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_LOAD  = 3'd0,
    PH_SERVE = 3'd1,
    PH_PLAY  = 3'd2,
    PH_LOST  = 3'd3,
    PH_CLEAR = 3'd4,
    PH_OVER  = 3'd5
  } phase_e;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic logic [2:0] next_level(input logic [2:0] lvl, input logic [2:0] last);
    return (lvl == last) ? 3'd0 : lvl + 3'd1;
  endfunction

endpackage

// File: rtl/game_state_sequencer_frame_delay_timer.sv
// Frame counter shared by the LOST and CLEAR delays; holds at zero while
// cleared and flags when the count has reached the selected limit.
module frame_delay_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/game_state_sequencer.sv
// Game-flow FSM: one physics step per frame, level loads, serve hold,
// lives bookkeeping, inter-round delays and the game-over/restart cycle.
module game_state_sequencer
  import game_state_sequencer_pkg::*;
#(
  parameter int START_LIVES        = 5,
  parameter int LOST_DELAY_FRAMES  = 60,
  parameter int CLEAR_DELAY_FRAMES = 90,
  parameter int LEVEL_COUNT        = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              FRAME_RENDERED,
  input  logic              BTN_RELEASE,
  input  logic              SW_PAUSE,
  input  logic              SW_IGNORE_DEATH,
  input  logic              STEP_COMPLETE,
  input  logic              BALL_LOST,
  input  logic [6:0]        BLOCKS_LEFT,
  input  logic              LOAD_DONE,
  output logic              START_UPDATE,
  output logic              LOAD_LEVEL,
  output logic              BALL_HELD,
  output logic              SCORE_CLEAR,
  output logic [2:0]        LIVES,
  output logic [2:0]        LEVEL,
  output logic              GAME_OVER,
  output logic [2:0]        PHASE,
  output logic [DROP_W-1:0] FRAME_DROPS
);

  localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);
  localparam logic [2:0] LEVEL_LAST  = 3'(LEVEL_COUNT - 1);
  localparam logic [7:0] LOST_LIMIT  = 8'(LOST_DELAY_FRAMES);
  localparam logic [7:0] CLEAR_LIMIT = 8'(CLEAR_DELAY_FRAMES);

  phase_e     phase;
  logic       busy;
  logic       btn_prev;
  logic       timer_done;
  logic       frame_ok;
  logic       step_done;
  logic       release_edge;
  logic       step_phase;
  logic       in_delay;
  logic       clear_hit;
  logic       death;
  logic       play_exit;
  logic [2:0] lives_dec;
  logic [7:0] delay_limit;

  assign frame_ok     = FRAME_RENDERED && !SW_PAUSE;
  assign step_done    = STEP_COMPLETE && busy;
  assign release_edge = BTN_RELEASE && !btn_prev;
  assign step_phase   = (phase == PH_SERVE) || (phase == PH_PLAY);
  assign in_delay     = (phase == PH_LOST) || (phase == PH_CLEAR);
  assign clear_hit    = (BLOCKS_LEFT == 7'd0);
  assign death        = BALL_LOST && !SW_IGNORE_DEATH;
  // A completing step that ends the round must not launch another one.
  assign play_exit    = (phase == PH_PLAY) && step_done && (clear_hit || death);
  assign lives_dec    = LIVES - 3'd1;
  assign delay_limit  = (phase == PH_CLEAR) ? CLEAR_LIMIT : LOST_LIMIT;
  assign PHASE        = phase;

  frame_delay_timer u_delay (
    .clk     (CLK),
    .reset_n (RESET_N),
    .clear   (!in_delay),
    .enable  (in_delay && frame_ok),
    .limit   (delay_limit),
    .done    (timer_done)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      phase        <= PH_LOAD;
      LIVES        <= LIVES_INIT;
      LEVEL        <= 3'd0;
      GAME_OVER    <= 1'b0;
      BALL_HELD    <= 1'b1;
      LOAD_LEVEL   <= 1'b1;
      START_UPDATE <= 1'b0;
      SCORE_CLEAR  <= 1'b0;
      FRAME_DROPS  <= '0;
      busy         <= 1'b0;
      btn_prev     <= 1'b1;
    end else begin
      btn_prev     <= BTN_RELEASE;
      START_UPDATE <= 1'b0;
      SCORE_CLEAR  <= 1'b0;

      // Completion is retired before the same-cycle frame is considered.
      if (step_done) busy <= 1'b0;
      if (step_phase && frame_ok && !play_exit) begin
        if (!busy || step_done) begin
          START_UPDATE <= 1'b1;
          busy         <= 1'b1;
        end else if (FRAME_DROPS != DROP_MAX) begin
          FRAME_DROPS <= FRAME_DROPS + 1'b1;
        end
      end

      case (phase)
        PH_LOAD: begin
          if (LOAD_DONE) begin
            phase      <= PH_SERVE;
            LOAD_LEVEL <= 1'b0;
          end
        end
        PH_SERVE: begin
          if (release_edge && !SW_PAUSE) begin
            phase     <= PH_PLAY;
            BALL_HELD <= 1'b0;
          end
        end
        PH_PLAY: begin
          if (step_done) begin
            if (clear_hit) begin
              phase <= PH_CLEAR;
            end else if (death) begin
              LIVES <= lives_dec;
              if (lives_dec == 3'd0) begin
                phase     <= PH_OVER;
                GAME_OVER <= 1'b1;
              end else begin
                phase <= PH_LOST;
              end
            end
          end
        end
        PH_LOST: begin
          if (timer_done) begin
            phase     <= PH_SERVE;
            BALL_HELD <= 1'b1;
          end
        end
        PH_CLEAR: begin
          if (timer_done) begin
            phase      <= PH_LOAD;
            LEVEL      <= next_level(LEVEL, LEVEL_LAST);
            LOAD_LEVEL <= 1'b1;
            BALL_HELD  <= 1'b1;
          end
        end
        PH_OVER: begin
          if (release_edge) begin
            phase       <= PH_LOAD;
            LIVES       <= LIVES_INIT;
            LEVEL       <= 3'd0;
            SCORE_CLEAR <= 1'b1;
            GAME_OVER   <= 1'b0;
            LOAD_LEVEL  <= 1'b1;
            BALL_HELD   <= 1'b1;
          end
        end
        default: begin
          phase      <= PH_LOAD;
          GAME_OVER  <= 1'b0;
          LOAD_LEVEL <= 1'b1;
          BALL_HELD  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer: load, serve, lives to game over,
// restart, level clears with wrap, frame drops and mid-play reset.
module tb_game_state_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       FRAME_RENDERED = 1'b0;
  logic       BTN_RELEASE = 1'b0;
  logic       SW_PAUSE = 1'b0;
  logic       SW_IGNORE_DEATH = 1'b0;
  logic       STEP_COMPLETE = 1'b0;
  logic       BALL_LOST = 1'b0;
  logic [6:0] BLOCKS_LEFT = 7'd10;
  logic       LOAD_DONE = 1'b0;
  logic       START_UPDATE, LOAD_LEVEL, BALL_HELD, SCORE_CLEAR, GAME_OVER;
  logic [2:0] LIVES, LEVEL, PHASE;
  logic [7:0] FRAME_DROPS;

  int tests_run = 0;
  int failed = 0;

  game_state_sequencer #(
    .START_LIVES(5), .LOST_DELAY_FRAMES(3), .CLEAR_DELAY_FRAMES(2), .LEVEL_COUNT(4)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_RENDERED(FRAME_RENDERED),
    .BTN_RELEASE(BTN_RELEASE), .SW_PAUSE(SW_PAUSE), .SW_IGNORE_DEATH(SW_IGNORE_DEATH),
    .STEP_COMPLETE(STEP_COMPLETE), .BALL_LOST(BALL_LOST), .BLOCKS_LEFT(BLOCKS_LEFT),
    .LOAD_DONE(LOAD_DONE), .START_UPDATE(START_UPDATE), .LOAD_LEVEL(LOAD_LEVEL),
    .BALL_HELD(BALL_HELD), .SCORE_CLEAR(SCORE_CLEAR), .LIVES(LIVES), .LEVEL(LEVEL),
    .GAME_OVER(GAME_OVER), .PHASE(PHASE), .FRAME_DROPS(FRAME_DROPS)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_frame();
    FRAME_RENDERED = 1'b1;
    tick();
    FRAME_RENDERED = 1'b0;
  endtask

  task automatic release_btn();
    BTN_RELEASE = 1'b1;
    tick();
    BTN_RELEASE = 1'b0;
  endtask

  task automatic pulse_load_done();
    LOAD_DONE = 1'b1;
    tick();
    LOAD_DONE = 1'b0;
  endtask

  task automatic run_step(input logic lost, input logic [6:0] blocks);
    pulse_frame();
    tick();
    STEP_COMPLETE = 1'b1;
    BALL_LOST     = lost;
    BLOCKS_LEFT   = blocks;
    tick();
    STEP_COMPLETE = 1'b0;
    BALL_LOST     = 1'b0;
    BLOCKS_LEFT   = 7'd10;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    tests_run++; if (PHASE !== 3'd0) begin failed++; $display("FAIL reset_phase: got %0d expected 0", PHASE); end
    tests_run++; if (LIVES !== 3'd5) begin failed++; $display("FAIL reset_lives: got %0d expected 5", LIVES); end
    tests_run++; if (LEVEL !== 3'd0) begin failed++; $display("FAIL reset_level: got %0d expected 0", LEVEL); end
    tests_run++; if (GAME_OVER !== 1'b0) begin failed++; $display("FAIL reset_game_over: got %0b expected 0", GAME_OVER); end
    tests_run++; if (BALL_HELD !== 1'b1) begin failed++; $display("FAIL reset_ball_held: got %0b expected 1", BALL_HELD); end
    tests_run++; if (START_UPDATE !== 1'b0) begin failed++; $display("FAIL reset_start_update: got %0b expected 0", START_UPDATE); end
    tests_run++; if (SCORE_CLEAR !== 1'b0) begin failed++; $display("FAIL reset_score_clear: got %0b expected 0", SCORE_CLEAR); end
    tests_run++; if (FRAME_DROPS !== 8'd0) begin failed++; $display("FAIL reset_drops: got %0d expected 0", FRAME_DROPS); end
  endtask

  task automatic test_load();
    int highs = 0;
    RESET_N = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (LOAD_LEVEL === 1'b1) highs++;
      if (c == 4) pulse_load_done();
      else tick();
    end
    tests_run++; if (highs != 4) begin failed++; $display("FAIL load_level_cycles: got %0d expected 4", highs); end
    tests_run++; if (LOAD_LEVEL !== 1'b0) begin failed++; $display("FAIL load_level_drop: got %0b expected 0", LOAD_LEVEL); end
    tests_run++; if (PHASE !== 3'd1) begin failed++; $display("FAIL load_phase: got %0d expected 1", PHASE); end
    tests_run++; if (BALL_HELD !== 1'b1) begin failed++; $display("FAIL load_ball_held: got %0b expected 1", BALL_HELD); end
    tests_run++; if (LIVES !== 3'd5) begin failed++; $display("FAIL load_lives: got %0d expected 5", LIVES); end
  endtask

  task automatic test_serve();
    int pulses = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      if (START_UPDATE === 1'b1) pulses++;
      tick();
      if (START_UPDATE === 1'b1) pulses++;
      STEP_COMPLETE = 1'b1;
      tick();
      STEP_COMPLETE = 1'b0;
    end
    tests_run++; if (pulses != 3) begin failed++; $display("FAIL serve_step_pulses: got %0d expected 3", pulses); end
    tests_run++; if (PHASE !== 3'd1) begin failed++; $display("FAIL serve_hold_phase: got %0d expected 1", PHASE); end
    SW_PAUSE = 1'b1;
    FRAME_RENDERED = 1'b1;
    BTN_RELEASE = 1'b1;
    tick();
    FRAME_RENDERED = 1'b0;
    tests_run++; if (START_UPDATE !== 1'b0) begin failed++; $display("FAIL pause_no_step: got %0b expected 0", START_UPDATE); end
    tick();
    BTN_RELEASE = 1'b0;
    tests_run++; if (PHASE !== 3'd1) begin failed++; $display("FAIL pause_no_serve: got %0d expected 1", PHASE); end
    SW_PAUSE = 1'b0;
    tick();
    release_btn();
    tests_run++; if (PHASE !== 3'd2) begin failed++; $display("FAIL serve_to_play: got %0d expected 2", PHASE); end
    tests_run++; if (BALL_HELD !== 1'b0) begin failed++; $display("FAIL play_ball_free: got %0b expected 0", BALL_HELD); end
  endtask

  task automatic test_lives();
    for (int k = 1; k <= 5; k++) begin
      run_step(1'b1, 7'd10);
      tests_run++; if (LIVES !== 3'(5 - k)) begin failed++; $display("FAIL lives_%0d: got %0d expected %0d", k, LIVES, 5 - k); end
      if (k < 5) begin
        tests_run++; if (PHASE !== 3'd3) begin failed++; $display("FAIL lost_phase_%0d: got %0d expected 3", k, PHASE); end
        pulse_frame();
        pulse_frame();
        tests_run++; if (START_UPDATE !== 1'b0) begin failed++; $display("FAIL lost_no_step_%0d: got %0b expected 0", k, START_UPDATE); end
        tests_run++; if (PHASE !== 3'd3) begin failed++; $display("FAIL lost_hold_%0d: got %0d expected 3", k, PHASE); end
        pulse_frame();
        tick();
        tests_run++; if (PHASE !== 3'd1) begin failed++; $display("FAIL lost_reserve_%0d: got %0d expected 1", k, PHASE); end
        release_btn();
      end
    end
    tests_run++; if (PHASE !== 3'd5) begin failed++; $display("FAIL over_phase: got %0d expected 5", PHASE); end
    tests_run++; if (GAME_OVER !== 1'b1) begin failed++; $display("FAIL over_flag: got %0b expected 1", GAME_OVER); end
  endtask

  task automatic test_restart();
    tick();
    release_btn();
    tests_run++; if (PHASE !== 3'd0) begin failed++; $display("FAIL restart_phase: got %0d expected 0", PHASE); end
    tests_run++; if (SCORE_CLEAR !== 1'b1) begin failed++; $display("FAIL restart_score_clear: got %0b expected 1", SCORE_CLEAR); end
    tests_run++; if (LIVES !== 3'd5) begin failed++; $display("FAIL restart_lives: got %0d expected 5", LIVES); end
    tests_run++; if (LEVEL !== 3'd0) begin failed++; $display("FAIL restart_level: got %0d expected 0", LEVEL); end
    tests_run++; if (GAME_OVER !== 1'b0) begin failed++; $display("FAIL restart_game_over: got %0b expected 0", GAME_OVER); end
    tick();
    tests_run++; if (SCORE_CLEAR !== 1'b0) begin failed++; $display("FAIL restart_score_pulse: got %0b expected 0", SCORE_CLEAR); end
    pulse_load_done();
    release_btn();
  endtask

  task automatic test_level_clear();
    for (int lv = 0; lv < 4; lv++) begin
      run_step(lv == 3, 7'd0);
      tests_run++; if (PHASE !== 3'd4) begin failed++; $display("FAIL clear_phase_%0d: got %0d expected 4", lv, PHASE); end
      tests_run++; if (LIVES !== 3'd5) begin failed++; $display("FAIL clear_lives_%0d: got %0d expected 5", lv, LIVES); end
      pulse_frame();
      pulse_frame();
      tick();
      tests_run++; if (PHASE !== 3'd0) begin failed++; $display("FAIL clear_to_load_%0d: got %0d expected 0", lv, PHASE); end
      tests_run++; if (LEVEL !== 3'((lv + 1) % 4)) begin failed++; $display("FAIL clear_level_%0d: got %0d expected %0d", lv, LEVEL, (lv + 1) % 4); end
      pulse_load_done();
      release_btn();
    end
  endtask

  task automatic test_back_to_back();
    pulse_frame();
    tests_run++; if (START_UPDATE !== 1'b1) begin failed++; $display("FAIL drop_first_step: got %0b expected 1", START_UPDATE); end
    pulse_frame();
    pulse_frame();
    tests_run++; if (FRAME_DROPS !== 8'd2) begin failed++; $display("FAIL drop_count: got %0d expected 2", FRAME_DROPS); end
    FRAME_RENDERED = 1'b1;
    STEP_COMPLETE  = 1'b1;
    tick();
    FRAME_RENDERED = 1'b0;
    STEP_COMPLETE  = 1'b0;
    tests_run++; if (START_UPDATE !== 1'b1) begin failed++; $display("FAIL same_cycle_step: got %0b expected 1", START_UPDATE); end
    tests_run++; if (FRAME_DROPS !== 8'd2) begin failed++; $display("FAIL same_cycle_drops: got %0d expected 2", FRAME_DROPS); end
    FRAME_RENDERED = 1'b1;
    repeat (300) tick();
    FRAME_RENDERED = 1'b0;
    tests_run++; if (FRAME_DROPS !== 8'd255) begin failed++; $display("FAIL drop_saturate: got %0d expected 255", FRAME_DROPS); end
  endtask

  task automatic test_reset_mid();
    RESET_N = 1'b0;
    BTN_RELEASE = 1'b1;
    tick();
    tests_run++; if (PHASE !== 3'd0) begin failed++; $display("FAIL mid_reset_phase: got %0d expected 0", PHASE); end
    tests_run++; if (FRAME_DROPS !== 8'd0) begin failed++; $display("FAIL mid_reset_drops: got %0d expected 0", FRAME_DROPS); end
    RESET_N = 1'b1;
    tick();
    STEP_COMPLETE = 1'b1;
    tick();
    STEP_COMPLETE = 1'b0;
    tests_run++; if (PHASE !== 3'd0) begin failed++; $display("FAIL late_complete_phase: got %0d expected 0", PHASE); end
    tests_run++; if (LOAD_LEVEL !== 1'b1) begin failed++; $display("FAIL late_complete_load: got %0b expected 1", LOAD_LEVEL); end
    tests_run++; if (START_UPDATE !== 1'b0) begin failed++; $display("FAIL late_complete_step: got %0b expected 0", START_UPDATE); end
    pulse_load_done();
    pulse_frame();
    tests_run++; if (START_UPDATE !== 1'b1) begin failed++; $display("FAIL busy_forgotten: got %0b expected 1", START_UPDATE); end
    tests_run++; if (PHASE !== 3'd1) begin failed++; $display("FAIL held_btn_no_serve: got %0d expected 1", PHASE); end
    tests_run++; if (FRAME_DROPS !== 8'd0) begin failed++; $display("FAIL post_reset_drops: got %0d expected 0", FRAME_DROPS); end
    BTN_RELEASE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_serve();
    test_lives();
    test_restart();
    test_level_clear();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
